cskip_adder_pipe: RTL and testbench

Parametrised, pipelined carry-skip adder/subtractor. It generalises the fixed 64-bit combinational carry-skip adder to any width, skip-block size and pipeline depth, and adds carry-in, subtract mode, signed overflow and valid/ready flow control. It sits in the adder library as the throughput-oriented carry-skip variant, drop-in for datapaths that stream operands every cycle.

---
 rtl/cskip_pkg.sv | 30 +++
 rtl/cskip_slice.sv | 44 ++++
 rtl/cskip_adder_pipe.sv | 137 +++++++++++++
 tb/tb_cskip_adder_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cskip_pkg.sv
// Shared helpers for the pipelined carry-skip adder: default geometry,
// parameter legality check and the pipeline depth derived from it.
package cskip_pkg;

  localparam int DefWidth        = 64;
  localparam int DefBlk          = 4;
  localparam int DefBlksPerStage = 4;

  // True when every parameter is positive and the width splits evenly into
  // whole pipeline stages of whole skip blocks.
  function automatic bit paramsOk(input int width, input int blk, input int blksPerStage);
    if (width < 1 || blk < 1 || blksPerStage < 1) begin
      return 1'b0;
    end
    if ((width % (blk * blksPerStage)) != 0) begin
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // Number of pipeline stages; falls back to 1 for illegal geometry so that
  // elaboration reaches the explicit check instead of dividing by zero.
  function automatic int stages(input int width, input int blk, input int blksPerStage);
    if (!paramsOk(width, blk, blksPerStage)) begin
      return 1;
    end
    return width / (blk * blksPerStage);
  endfunction

endpackage

// File: rtl/cskip_slice.sv
// Combinational carry-skip slice: NBLK blocks of BLK rippled bits each.
// A block whose bits all propagate passes its carry-in straight to its
// carry-out, bypassing the ripple chain.
module cskip_slice #(
  parameter int BLK  = 4,
  parameter int NBLK = 4
) (
  input  logic [BLK*NBLK-1:0] a_i,
  input  logic [BLK*NBLK-1:0] b_i,
  input  logic                cin_i,
  output logic [BLK*NBLK-1:0] sum_o,
  output logic                cout_o,
  output logic                cmsb_o
);

  // Ripple inside each block, skip across blocks; cmsb_o ends up holding the
  // carry into the most significant bit of the slice.
  always_comb begin
    logic carry;
    logic blkIn;
    logic allProp;
    logic p;
    sum_o   = '0;
    cmsb_o  = 1'b0;
    carry   = cin_i;
    blkIn   = 1'b0;
    allProp = 1'b0;
    p       = 1'b0;
    for (int j = 0; j < NBLK; j++) begin
      blkIn   = carry;
      allProp = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        p                  = a_i[j*BLK+i] ^ b_i[j*BLK+i];
        sum_o[j*BLK+i]     = p ^ carry;
        cmsb_o             = carry;
        carry              = (a_i[j*BLK+i] & b_i[j*BLK+i]) | (p & carry);
        allProp            = allProp & p;
      end
      carry = allProp ? blkIn : carry;
    end
    cout_o = carry;
  end

endmodule

// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor with valid/ready flow control.
// Stage k adds bits [k*SW +: SW] using the carry registered by stage k-1;
// the last stage's registers are the output registers.
module cskip_adder_pipe
  import cskip_pkg::*;
#(
  parameter int WIDTH          = DefWidth,
  parameter int BLK            = DefBlk,
  parameter int BLKS_PER_STAGE = DefBlksPerStage
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW     = BLK * BLKS_PER_STAGE;
  localparam int STAGES = stages(WIDTH, BLK, BLKS_PER_STAGE);

  if (!paramsOk(WIDTH, BLK, BLKS_PER_STAGE)) begin : gParamCheck
    $fatal(1, "cskip_adder_pipe: WIDTH must be a positive multiple of BLK*BLKS_PER_STAGE");
  end

  // Index k of these arrays is what stage k consumes; index STAGES is the
  // output register set.
  logic             stValid [0:STAGES];
  logic             stCarry [0:STAGES];
  logic             stCmsb  [0:STAGES];
  logic [WIDTH-1:0] stA     [0:STAGES];
  logic [WIDTH-1:0] stB     [0:STAGES];
  logic [WIDTH-1:0] stSum   [0:STAGES];

  logic en;

  // The whole pipeline moves together; it only stops when a finished result
  // is waiting and the consumer is not taking it.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign stValid[0] = in_valid;
  assign stCarry[0] = sub | cin;
  assign stCmsb[0]  = 1'b0;
  assign stA[0]     = a;
  assign stB[0]     = sub ? ~b : b;
  assign stSum[0]   = '0;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    localparam int Lo = k * SW;

    logic [SW-1:0]    sliceSum;
    logic             sliceCout;
    logic             sliceCmsb;
    logic [WIDTH-1:0] sum_d;
    logic             valid_q;
    logic             carry_q;
    logic             cmsb_q;
    logic [WIDTH-1:0] sum_q;

    cskip_slice #(
      .BLK  (BLK),
      .NBLK (BLKS_PER_STAGE)
    ) uSlice (
      .a_i    (stA[k][Lo +: SW]),
      .b_i    (stB[k][Lo +: SW]),
      .cin_i  (stCarry[k]),
      .sum_o  (sliceSum),
      .cout_o (sliceCout),
      .cmsb_o (sliceCmsb)
    );

    // Merge this stage's slice into the low bits already completed upstream.
    always_comb begin
      sum_d            = stSum[k];
      sum_d[Lo +: SW]  = sliceSum;
    end

    // Valid follows the pipeline on every advance; data only loads for a
    // real beat so the output holds its last result across bubbles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        cmsb_q  <= 1'b0;
        sum_q   <= '0;
      end else if (en) begin
        valid_q <= stValid[k];
        if (stValid[k]) begin
          carry_q <= sliceCout;
          cmsb_q  <= sliceCmsb;
          sum_q   <= sum_d;
        end
      end
    end

    assign stValid[k+1] = valid_q;
    assign stCarry[k+1] = carry_q;
    assign stCmsb[k+1]  = cmsb_q;
    assign stSum[k+1]   = sum_q;

    if (k < STAGES - 1) begin : gOperands
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      // Carry the not-yet-added operand bits forward to the later stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en && stValid[k]) begin
          a_q <= stA[k];
          b_q <= stB[k];
        end
      end

      assign stA[k+1] = a_q;
      assign stB[k+1] = b_q;
    end else begin : gLastStage
      assign stA[k+1] = '0;
      assign stB[k+1] = '0;
    end
  end

  assign out_valid = stValid[STAGES];
  assign sum       = stSum[STAGES];
  assign cout      = stCarry[STAGES];
  assign ovf       = stCmsb[STAGES] ^ stCarry[STAGES];

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Directed bench for cskip_adder_pipe: a default 64-bit/4-stage instance and
// a 32-bit/2-stage instance sharing clock and reset.
module tb_cskip_adder_pipe;

  logic clk = 1'b0;
  logic rst;

  logic        inValid, inReady, cinW, subW, outValid, outReady, cout, ovf;
  logic [63:0] a, b, sum;

  logic        inValidN, inReadyN, cinN, subN, outValidN, outReadyN, coutN, ovfN;
  logic [31:0] aN, bN, sumN;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cskip_adder_pipe uDut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (a),
    .b         (b),
    .cin       (cinW),
    .sub       (subW),
    .out_valid (outValid),
    .out_ready (outReady),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  cskip_adder_pipe #(
    .WIDTH          (32),
    .BLK            (8),
    .BLKS_PER_STAGE (2)
  ) uDutNarrow (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValidN),
    .in_ready  (inReadyN),
    .a         (aN),
    .b         (bN),
    .cin       (cinN),
    .sub       (subN),
    .out_valid (outValidN),
    .out_ready (outReadyN),
    .sum       (sumN),
    .cout      (coutN),
    .ovf       (ovfN)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit narrow, input logic v, input logic [63:0] opA,
                               input logic [63:0] opB, input logic c, input logic s);
    if (narrow) begin
      inValidN = v;
      aN       = opA[31:0];
      bN       = opB[31:0];
      cinN     = c;
      subN     = s;
    end else begin
      inValid = v;
      a       = opA;
      b       = opB;
      cinW    = c;
      subW    = s;
    end
  endtask

  // One beat into an empty pipe, called at a falling edge; checks the exact
  // latency and the result, then that the output slot empties again.
  task automatic singleBeat(input bit narrow, input string tag, input logic [63:0] opA,
                            input logic [63:0] opB, input logic c, input logic s,
                            input logic [63:0] eSum, input logic eCout, input logic eOvf);
    int lat;
    lat = narrow ? 2 : 4;
    applyStimulus(narrow, 1'b1, opA, opB, c, s);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (i == 1) applyStimulus(narrow, 1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput({tag, " early valid"}, narrow ? outValidN : outValid, 64'd0);
    end
    @(negedge clk);
    if (lat == 1) applyStimulus(narrow, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput({tag, " valid"}, narrow ? outValidN : outValid, 64'd1);
    checkOutput({tag, " sum"},   narrow ? {32'd0, sumN} : sum, eSum);
    checkOutput({tag, " cout"},  narrow ? coutN : cout, {63'd0, eCout});
    checkOutput({tag, " ovf"},   narrow ? ovfN : ovf, {63'd0, eOvf});
    @(negedge clk);
    checkOutput({tag, " drained"}, narrow ? outValidN : outValid, 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tx;
    int rx;

    rst       = 1'b1;
    outReady  = 1'b1;
    outReadyN = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    checkOutput("rst out_valid", outValid, 64'd0);
    checkOutput("rst sum",       sum,      64'd0);
    checkOutput("rst cout",      cout,     64'd0);
    checkOutput("rst ovf",       ovf,      64'd0);
    checkOutput("rst in_ready",  inReady,  64'd1);
    checkOutput("rst narrow out_valid", outValidN, 64'd0);
    checkOutput("rst narrow sum",       sumN,      64'd0);

    rst = 1'b0;
    @(negedge clk);

    singleBeat(1'b0, "998+128", 64'd998, 64'd128, 1'b0, 1'b0, 64'd1126, 1'b0, 1'b0);

    // Three beats on consecutive cycles come out on consecutive cycles.
    applyStimulus(1'b0, 1'b1, 64'd9998, 64'd9028, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 64'd999909989998, 64'd769028, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 64'd1, 64'd1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("b2b early valid", outValid, 64'd0);
    @(negedge clk);
    checkOutput("b2b first valid", outValid, 64'd1);
    checkOutput("b2b first sum",   sum,      64'd19026);
    @(negedge clk);
    checkOutput("b2b second valid", outValid, 64'd1);
    checkOutput("b2b second sum",   sum,      64'd999910759026);
    @(negedge clk);
    checkOutput("b2b third valid", outValid, 64'd1);
    checkOutput("b2b third sum",   sum,      64'd3);
    checkOutput("b2b third cout",  cout,     64'd0);
    @(negedge clk);
    checkOutput("b2b drained", outValid, 64'd0);

    singleBeat(1'b0, "ones+cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
               64'd0, 1'b1, 1'b0);
    singleBeat(1'b0, "maxpos+1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
    singleBeat(1'b0, "allprop cin1", 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0,
               64'd0, 1'b1, 1'b0);
    singleBeat(1'b0, "allprop cin0", 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    singleBeat(1'b0, "5-7", 64'd5, 64'd7, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    singleBeat(1'b0, "7-5 cin ignored", 64'd7, 64'd5, 1'b1, 1'b1,
               64'd2, 1'b1, 1'b0);
    singleBeat(1'b0, "minneg-1", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Streaming with the consumer stalled for five cycles in the middle.
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      outReady = !(cyc >= 6 && cyc < 11);
      if (tx < 8) applyStimulus(1'b0, 1'b1, 64'h1000 + 64'(tx), 64'(tx), 1'b0, 1'b0);
      else        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      checkOutput("bp in_ready", inReady, {63'd0, (!outValid || outReady)});
      if (!outReady) checkOutput("bp stall valid", outValid, 64'd1);
      if (outValid) begin
        checkOutput("bp sum", sum, 64'h1000 + 64'(2 * rx));
        if (outReady) rx++;
      end
      if (inValid && inReady) tx++;
    end
    checkOutput("bp beats sent",     64'(tx), 64'd8);
    checkOutput("bp beats received", 64'(rx), 64'd8);
    outReady = 1'b1;

    // Reset with one result at the output and two more behind it.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 64'd10, 64'd20, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 64'd30, 64'd40, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 64'd50, 64'd60, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pre-rst valid", outValid, 64'd1);
    checkOutput("pre-rst sum",   sum,      64'd30);
    rst = 1'b1;
    #1;
    checkOutput("mid-rst valid", outValid, 64'd0);
    checkOutput("mid-rst sum",   sum,      64'd0);
    checkOutput("mid-rst cout",  cout,     64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post-rst no stale", outValid, 64'd0);
    end
    singleBeat(1'b0, "post-rst 1+2", 64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0);

    singleBeat(1'b1, "n ones+cin", 64'hFFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    singleBeat(1'b1, "n maxpos+1", 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
    singleBeat(1'b1, "n 5-7", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0);
    singleBeat(1'b1, "n 1+2", 64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
